// File: rtl/score_keeper_pkg.sv
// Shared definitions for the score keeper slice.
//   color_e     : block colour codes, same encoding the collision module drives
//   bcd_state_e : states of the sequential binary-to-BCD converter
//   DEF_*       : default widths and point values
package score_keeper_pkg;

  typedef enum logic [1:0] {
    COL_NONE  = 2'b00,
    COL_GREEN = 2'b01,
    COL_BLUE  = 2'b10,
    COL_RED   = 2'b11
  } color_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } bcd_state_e;

  localparam int DEF_SCORE_W    = 7;
  localparam int DEF_GREEN_PTS  = 2;
  localparam int DEF_BLUE_PTS   = 5;
  localparam int DEF_RED_PTS    = 3;
  localparam int DEF_COMBO_LEN  = 3;
  localparam int DEF_STREAK_W   = 4;
  localparam int DEF_BCD_DIGITS = 3;

endpackage

// File: rtl/score_keeper_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin converting bin (accepted in IDLE and in DONE)
//   bin      : binary value, latched when start is accepted
//   bcd      : last completed result, digit 0 in bits [3:0]; updated in DONE
//   done     : high during the DONE cycle
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | W add-3/shift iterations on the shadow register
// DONE  | copy shadow to bcd; restart immediately if start is high
module bin2bcd_seq
  import score_keeper_pkg::*;
#(
  parameter int W      = DEF_SCORE_W,
  parameter int DIGITS = DEF_BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int CNT_W = $clog2(W + 1);

  bcd_state_e            state, state_nxt;
  logic [W-1:0]          bin_sh;
  logic [4*DIGITS-1:0]   shadow;
  logic [4*DIGITS-1:0]   adj;
  logic [CNT_W-1:0]      cnt;

  always_comb begin
    adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      adj[4*d +: 4] = (shadow[4*d +: 4] >= 4'd5) ? shadow[4*d +: 4] + 4'd3
                                                  : shadow[4*d +: 4];
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sh <= '0;
      shadow <= '0;
      cnt    <= '0;
      bcd    <= '0;
    end else begin
      if (state == DONE) bcd <= shadow;
      if ((state == IDLE || state == DONE) && start) begin
        bin_sh <= bin;
        shadow <= '0;
        cnt    <= CNT_W'(W);
      end else if (state == SHIFT) begin
        {shadow, bin_sh} <= {adj, bin_sh} << 1;
        cnt              <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Score keeper: edge-detects collisions, applies colour point rules with a
// combo multiplier, saturates, tracks the session high score and keeps a
// BCD copy of the score for the display driver.
//   clk, rst   : clock, asynchronous active-high reset
//   collision  : level from the collision module, one hit per rising edge
//   color      : colour of the hit block (none/green/blue/red)
//   new_round  : one-cycle pulse, clears score and streak
//   score      : current score
//   high_score : maximum score since reset (one cycle behind score)
//   streak     : consecutive non-red hit count, saturating
//   score_upd  : pulse in the first cycle a new score is visible
//   bcd        : BCD of the last converted score
//   bcd_valid  : high while bcd matches score
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int SCORE_W    = DEF_SCORE_W,
  parameter int GREEN_PTS  = DEF_GREEN_PTS,
  parameter int BLUE_PTS   = DEF_BLUE_PTS,
  parameter int RED_PTS    = DEF_RED_PTS,
  parameter int COMBO_LEN  = DEF_COMBO_LEN,
  parameter int STREAK_W   = DEF_STREAK_W,
  parameter int BCD_DIGITS = DEF_BCD_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    collision,
  input  logic [1:0]              color,
  input  logic                    new_round,
  output logic [SCORE_W-1:0]      score,
  output logic [SCORE_W-1:0]      high_score,
  output logic [STREAK_W-1:0]     streak,
  output logic                    score_upd,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    bcd_valid
);

  localparam logic [SCORE_W+1:0] GREEN_W = (SCORE_W+2)'(GREEN_PTS);
  localparam logic [SCORE_W+1:0] BLUE_W  = (SCORE_W+2)'(BLUE_PTS);
  localparam logic [SCORE_W+1:0] RED_W   = (SCORE_W+2)'(RED_PTS);
  localparam logic [SCORE_W-1:0] FULL    = '1;

  logic               col_q;
  logic               hit;
  logic [SCORE_W+1:0] base;
  logic [SCORE_W+1:0] pts;
  logic [SCORE_W+1:0] sum_wide;
  logic [SCORE_W-1:0] score_add;
  logic [SCORE_W-1:0] score_sub;

  logic busy;
  logic pending;
  logic conv_start;
  logic conv_done;

  always_comb begin
    hit       = collision & ~col_q;
    base      = (color == COL_BLUE) ? BLUE_W : GREEN_W;
    // combo is judged on the streak before the current hit
    pts       = (int'(streak) >= COMBO_LEN) ? (base << 1) : base;
    sum_wide  = {2'b00, score} + pts;
    score_add = (sum_wide > {2'b00, FULL}) ? FULL : sum_wide[SCORE_W-1:0];
    score_sub = ({2'b00, score} < RED_W) ? '0 : score - RED_W[SCORE_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= 1'b0;
      score      <= '0;
      streak     <= '0;
      score_upd  <= 1'b0;
      high_score <= '0;
    end else begin
      col_q     <= collision;
      score_upd <= 1'b0;
      if (new_round) begin
        score     <= '0;
        streak    <= '0;
        score_upd <= 1'b1;
      end else if (hit && color != COL_NONE) begin
        score_upd <= 1'b1;
        if (color == COL_RED) begin
          score  <= score_sub;
          streak <= '0;
        end else begin
          score <= score_add;
          if (streak != '1) streak <= streak + STREAK_W'(1);
        end
      end
      if (score > high_score) high_score <= score;
    end
  end

  // An update arriving while a conversion is in flight is remembered and
  // converted from the then-current score as soon as the converter finishes.
  assign conv_start = (score_upd && !busy) || (conv_done && (pending || score_upd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      pending   <= 1'b0;
      bcd_valid <= 1'b1;
    end else begin
      if (conv_start) begin
        busy      <= 1'b1;
        pending   <= 1'b0;
        bcd_valid <= 1'b0;
      end else if (conv_done) begin
        busy      <= 1'b0;
        pending   <= 1'b0;
        bcd_valid <= 1'b1;
      end else if (score_upd && busy) begin
        pending <= 1'b1;
      end
    end
  end

  bin2bcd_seq #(
    .W      (SCORE_W),
    .DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (score),
    .bcd   (bcd),
    .done  (conv_done)
  );

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        collision = 1'b0;
  logic [1:0]  color = 2'b00;
  logic        new_round = 1'b0;
  logic [6:0]  score;
  logic [6:0]  high_score;
  logic [3:0]  streak;
  logic        score_upd;
  logic [11:0] bcd;
  logic        bcd_valid;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int  m_score, m_hs, m_streak;
  bit  m_colq, m_upd;
  bit  m_active;

  score_keeper dut (
    .clk        (clk),
    .rst        (rst),
    .collision  (collision),
    .color      (color),
    .new_round  (new_round),
    .score      (score),
    .high_score (high_score),
    .streak     (streak),
    .score_upd  (score_upd),
    .bcd        (bcd),
    .bcd_valid  (bcd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  task automatic model_reset();
    m_score = 0; m_hs = 0; m_streak = 0; m_colq = 0; m_upd = 0;
  endtask

  // one clock: update the model from the inputs seen at the edge, then compare
  task automatic cyc();
    int pts;
    bit hit;
    @(posedge clk);
    hit = collision && !m_colq;
    if (m_score > m_hs) m_hs = m_score;
    m_upd = 0;
    if (new_round) begin
      m_score = 0; m_streak = 0; m_upd = 1;
    end else if (hit && color != 2'b00) begin
      m_upd = 1;
      if (color == 2'b11) begin
        m_score  = (m_score < 3) ? 0 : m_score - 3;
        m_streak = 0;
      end else begin
        pts = (color == 2'b01) ? 2 : 5;
        if (m_streak >= 3) pts = pts * 2;
        m_score  = (m_score + pts > 127) ? 127 : m_score + pts;
        m_streak = (m_streak == 15) ? 15 : m_streak + 1;
      end
    end
    m_colq = collision;
    #1;
    chk("score", score, m_score);
    chk("streak", streak, m_streak);
    chk("score_upd", score_upd, m_upd);
    chk("high_score", high_score, m_hs);
  endtask

  task automatic hit(input logic [1:0] c);
    collision = 1'b1; color = c;
    cyc();
    collision = 1'b0; color = 2'b00;
    cyc();
  endtask

  task automatic settle_check(input string tag);
    collision = 1'b0; new_round = 1'b0;
    repeat (22) cyc();
    chk({tag, "_valid"}, bcd_valid, 1);
    chk({tag, "_bcd"}, bcd, to_bcd(m_score));
  endtask

  // hit, then count cycles with bcd_valid low
  task automatic latency_check(input logic [1:0] c, input int exp_bcd);
    int n;
    collision = 1'b1; color = c;
    cyc();
    collision = 1'b0; color = 2'b00;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (bcd_valid) break;
      n++;
    end
    chk("bcd_low_cycles", n, 8);
    chk("bcd_after_lat", bcd, exp_bcd);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_score", score, 0);
    chk("rst_hs", high_score, 0);
    chk("rst_streak", streak, 0);
    chk("rst_upd", score_upd, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_bcd_valid", bcd_valid, 1);

    // basic point rules and combo
    hit(2'b01); hit(2'b01); hit(2'b10);
    chk("tp_score9", score, 9);
    chk("tp_streak3", streak, 3);
    hit(2'b01);
    chk("tp_combo13", score, 13);
    hit(2'b11);
    chk("tp_red10", score, 10);
    hit(2'b01);
    chk("tp_nocombo12", score, 12);
    hit(2'b00);

    // held collision counts once
    collision = 1'b1; color = 2'b10;
    repeat (10) cyc();
    collision = 1'b0; color = 2'b00;
    cyc();
    chk("tp_held17", score, 17);

    // floor at zero
    new_round = 1'b1; cyc(); new_round = 1'b0;
    hit(2'b01); hit(2'b01); hit(2'b11);
    chk("tp_score1", score, 1);
    hit(2'b11);
    chk("tp_floor0", score, 0);
    hit(2'b11);

    // saturation
    new_round = 1'b1; cyc(); new_round = 1'b0;
    repeat (14) hit(2'b10);
    chk("tp_score125", score, 125);
    hit(2'b10);
    chk("tp_sat127", score, 127);
    hit(2'b10);
    chk("tp_sat_hold", score, 127);
    chk("tp_hs127", high_score, 127);
    settle_check("sat");

    // conversion latency
    latency_check(2'b11, 12'h124);
    latency_check(2'b10, 12'h127);

    // second update mid-conversion
    collision = 1'b1; color = 2'b11; cyc();
    collision = 1'b0; color = 2'b00; repeat (3) cyc();
    collision = 1'b1; color = 2'b11; cyc();
    collision = 1'b0; color = 2'b00;
    settle_check("midconv");
    chk("midconv_val", bcd, 12'h121);

    // new_round beats a simultaneous hit
    new_round = 1'b1; collision = 1'b1; color = 2'b10;
    cyc();
    new_round = 1'b0; collision = 1'b0; color = 2'b00;
    cyc();
    chk("nr_score", score, 0);
    chk("nr_streak", streak, 0);
    chk("nr_hs", high_score, 127);
    settle_check("nr");

    // reset in the middle of SHIFT
    hit(2'b01); hit(2'b01);
    collision = 1'b1; color = 2'b10; cyc();
    collision = 1'b0; color = 2'b00; cyc(); cyc();
    #3 rst = 1'b1;
    #1;
    chk("rstmid_bcd", bcd, 0);
    chk("rstmid_valid", bcd_valid, 1);
    chk("rstmid_score", score, 0);
    chk("rstmid_hs", high_score, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    cyc();

    // randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      for (int i = 0; i < 200; i++) begin
        collision = 1'($urandom_range(0, 1));
        color     = 2'($urandom_range(0, 3));
        new_round = ($urandom_range(0, 31) == 0);
        cyc();
      end
      settle_check("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
